// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator controller slice: floor constants,
// call-queue state encoding and a floor-to-one-hot helper.
package elevator_pkg;

  localparam int unsigned NFLOORS = 5;

  localparam logic [2:0] GND = 3'd0;
  localparam logic [2:0] FL1 = 3'd1;
  localparam logic [2:0] FL2 = 3'd2;
  localparam logic [2:0] FL3 = 3'd3;
  localparam logic [2:0] FL4 = 3'd4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StServe = 2'd1,
    StDoor  = 2'd2
  } call_state_e;

  // One-hot of a floor number; all-zero for floors outside 0..NFLOORS-1,
  // so an out-of-range floor never matches a call.
  function automatic logic [NFLOORS-1:0] floor_onehot(input logic [2:0] fl);
    floor_onehot = '0;
    for (int unsigned i = 0; i < NFLOORS; i++) begin
      if (fl == 3'(i)) floor_onehot[i] = 1'b1;
    end
  endfunction

endpackage

// File: rtl/elevator_btn_edge.sv
// Call-button rising-edge detector. The rise vector is registered, so a
// press reaches the call queue one cycle after the button is first sampled.
module elevator_btn_edge
  import elevator_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NFLOORS-1:0] btn,
  output logic [NFLOORS-1:0] rise
);

  logic [NFLOORS-1:0] btn_q;
  logic [NFLOORS-1:0] rise_q;

  // Previous button sample and registered rising edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_q  <= '0;
      rise_q <= '0;
    end else begin
      btn_q  <= btn;
      rise_q <= btn & ~btn_q;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/elevator_call_queue.sv
// Elevator call queue: latches call-button presses, drives request lines,
// opens the door for a fixed dwell on arrival and holds the car there.
module elevator_call_queue
  import elevator_pkg::*;
#(
  parameter int unsigned DWELL = 8,
  parameter int unsigned CW    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NFLOORS-1:0] btn,
  input  logic [2:0]         floor,
  output logic [NFLOORS-1:0] req,
  output logic [NFLOORS-1:0] pending,
  output logic               door_open,
  output logic               busy
);

  localparam logic [CW-1:0] RELOAD = CW'(DWELL - 1);

  call_state_e        state_q, state_d;
  logic [NFLOORS-1:0] pending_q, pending_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2:0]         door_fl_q, door_fl_d;

  logic [NFLOORS-1:0] rise;
  logic [NFLOORS-1:0] arr_hot;
  logic [NFLOORS-1:0] door_hot;

  elevator_btn_edge u_btn_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn),
    .rise  (rise)
  );

  assign arr_hot  = floor_onehot(floor);
  assign door_hot = floor_onehot(door_fl_q);

  // State, pending calls, dwell counter and latched door floor.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      pending_q <= '0;
      cnt_q     <= '0;
      door_fl_q <= GND;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      door_fl_q <= door_fl_d;
    end
  end

  // Next-state: call latching, arrival detection and dwell timing.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    cnt_d     = cnt_q;
    door_fl_d = door_fl_q;
    case (state_q)
      StIdle: begin
        if (|(rise & arr_hot)) begin
          // Call at the current floor opens the door without being latched.
          state_d   = StDoor;
          door_fl_d = floor;
          cnt_d     = RELOAD;
          pending_d = pending_q | (rise & ~arr_hot);
        end else if (|rise) begin
          state_d   = StServe;
          pending_d = pending_q | rise;
        end
      end
      StServe: begin
        pending_d = pending_q | rise;
        if (|(pending_q & arr_hot)) begin
          // Arrival wins over a same-cycle press on that floor.
          pending_d = pending_d & ~arr_hot;
          state_d   = StDoor;
          door_fl_d = floor;
          cnt_d     = RELOAD;
        end
      end
      StDoor: begin
        if (|(rise & door_hot)) begin
          // Re-press at the open floor extends the dwell.
          cnt_d     = RELOAD;
          pending_d = pending_q | (rise & ~door_hot);
        end else begin
          pending_d = pending_q | rise;
          if (cnt_q == '0) begin
            // Include this cycle's presses so none is stranded in idle.
            state_d = (|pending_d) ? StServe : StIdle;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decode registers only; the door floor request holds the car.
  always_comb begin
    req       = (state_q == StDoor) ? door_hot : pending_q;
    pending   = pending_q;
    door_open = (state_q == StDoor);
    busy      = (state_q != StIdle);
  end

endmodule

// File: tb/tb_elevator_call_queue.sv
// Self-checking bench for elevator_call_queue: directed scenarios plus a
// randomized run, all compared against a cycle-level behavioural model.
module tb_elevator_call_queue;

  localparam int DWELL = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] btn = '0;
  logic [2:0] floor = '0;
  logic [4:0] req;
  logic [4:0] pending;
  logic       door_open;
  logic       busy;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0=idle, 1=serving calls, 2=door open.
  int       m_mode;
  int       m_remain;
  int       m_fl;
  bit [4:0] m_pend;
  bit [4:0] m_btn_q;
  bit [4:0] m_rise;

  elevator_call_queue #(
    .DWELL (DWELL),
    .CW    (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn       (btn),
    .floor     (floor),
    .req       (req),
    .pending   (pending),
    .door_open (door_open),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_mode = 0; m_remain = 0; m_fl = 0;
    m_pend = '0; m_btn_q = '0; m_rise = '0;
  endfunction

  // One clock edge of the reference behaviour, from the call rules.
  function automatic void model_step(input bit [4:0] b, input int f);
    bit [4:0] r;
    bit [4:0] fh;
    bit [4:0] dh;
    bit       hit;
    r  = m_rise;
    fh = (f < 5) ? 5'(1 << f) : 5'b0;
    dh = 5'(1 << m_fl);
    case (m_mode)
      0: begin
        if ((r & fh) != 0) begin
          m_mode = 2; m_fl = f; m_remain = DWELL;
          m_pend |= r & ~fh;
        end else if (r != 0) begin
          m_mode = 1; m_pend |= r;
        end
      end
      1: begin
        hit = (m_pend & fh) != 0;
        m_pend |= r;
        if (hit) begin
          m_pend &= ~fh;
          m_mode = 2; m_fl = f; m_remain = DWELL;
        end
      end
      default: begin
        if ((r & dh) != 0) begin
          m_remain = DWELL;
          m_pend |= r & ~dh;
        end else begin
          m_pend |= r;
          if (m_remain == 1) m_mode = (m_pend != 0) ? 1 : 0;
          else m_remain--;
        end
      end
    endcase
    m_rise  = b & ~m_btn_q;
    m_btn_q = b;
  endfunction

  task automatic compare_model();
    bit [4:0] exp_req;
    exp_req = (m_mode == 2) ? 5'(1 << m_fl) : m_pend;
    check("req", 32'(req), 32'(exp_req));
    check("pending", 32'(pending), 32'(m_pend));
    check("door_open", 32'(door_open), 32'(m_mode == 2));
    check("busy", 32'(busy), 32'(m_mode != 0));
  endtask

  // Drive inputs at the falling edge, clock once, compare at the next falling edge.
  task automatic cycle(input bit [4:0] b, input int f);
    btn   = b;
    floor = 3'(f);
    @(posedge clk);
    model_step(b, f);
    @(negedge clk);
    compare_model();
  endtask

  task automatic do_reset(input bit [4:0] b);
    @(negedge clk);
    btn   = b;
    floor = '0;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_req", 32'(req), 32'(0));
    check("rst_door", 32'(door_open), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Run at floor flr until the door has opened and closed; optionally press
  // pb during the dwell cycle after press_at door cycles have been seen.
  task automatic run_door(input int flr, input int press_at, input bit [4:0] pb, output int n);
    bit done;
    bit [4:0] b;
    n = 0;
    done = 1'b0;
    for (int i = 0; i < 80 && !done; i++) begin
      b = (n == press_at) ? pb : 5'b0;
      cycle(b, flr);
      if (door_open) n++;
      else if (n > 0) done = 1'b1;
    end
    check("door_closed_in_time", 32'(done), 32'(1));
  endtask

  initial begin
    int n;
    int f;
    bit [4:0] b;
    model_reset();

    // 1: reset with buttons held, then latch after release.
    do_reset(5'b00110);
    cycle(5'b00110, 0);
    check("t1_req_early", 32'(req), 32'(0));
    cycle(5'b00110, 0);
    check("t1_req", 32'(req), 32'(5'b00110));
    check("t1_busy", 32'(busy), 32'(1));

    // 2: call floor 3, arrive, fixed dwell.
    do_reset(5'b0);
    cycle(5'b0, 0);
    cycle(5'b01000, 0);
    for (int i = 0; i < 4; i++) cycle(5'b0, 0);
    check("t2_pending", 32'(pending), 32'(5'b01000));
    run_door(3, -1, 5'b0, n);
    check("t2_dwell", 32'(n), 32'(DWELL));
    check("t2_pending_after", 32'(pending), 32'(0));
    check("t2_idle", 32'(busy), 32'(0));

    // 3: new call during dwell is queued, served after close.
    do_reset(5'b0);
    cycle(5'b0, 0);
    cycle(5'b01000, 0);
    cycle(5'b0, 0);
    cycle(5'b0, 0);
    run_door(3, 1, 5'b00010, n);
    check("t3_dwell", 32'(n), 32'(DWELL));
    check("t3_req", 32'(req), 32'(5'b00010));
    check("t3_busy", 32'(busy), 32'(1));

    // 4: re-press at the open floor extends the dwell.
    do_reset(5'b0);
    cycle(5'b0, 0);
    cycle(5'b01000, 0);
    cycle(5'b0, 0);
    cycle(5'b0, 0);
    run_door(3, 4, 5'b01000, n);
    check("t4_dwell", 32'(n), 32'(5 + DWELL));

    // 5: held button registers once; invalid floor never clears.
    do_reset(5'b0);
    for (int i = 0; i < 20; i++) cycle(5'b00100, 0);
    check("t5_pending", 32'(pending), 32'(5'b00100));
    cycle(5'b0, 0);
    run_door(2, -1, 5'b0, n);
    check("t5_dwell", 32'(n), 32'(DWELL));
    for (int i = 0; i < 3; i++) begin
      cycle(5'b0, 2);
      check("t5_no_reopen", 32'(door_open), 32'(0));
    end
    cycle(5'b11111, 7);
    for (int i = 0; i < 5; i++) cycle(5'b0, 7);
    check("t5_all_pending", 32'(pending), 32'(5'b11111));
    check("t5_no_door", 32'(door_open), 32'(0));

    // 6: asynchronous reset in the middle of a dwell.
    do_reset(5'b0);
    cycle(5'b0, 0);
    cycle(5'b10010, 0);
    cycle(5'b0, 0);
    cycle(5'b0, 0);
    cycle(5'b0, 4);
    cycle(5'b0, 4);
    check("t6_in_door", 32'(door_open), 32'(1));
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("t6_door", 32'(door_open), 32'(0));
    check("t6_req", 32'(req), 32'(0));
    check("t6_pending", 32'(pending), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic against the model.
    do_reset(5'b0);
    f = 0;
    for (int i = 0; i < 3000; i++) begin
      b = 5'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 5) == 0) f = $urandom_range(0, 7);
      cycle(b, f);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
